stack_controller: RTL

//  Stack-side initiator for the register bank's SP / stack interface. Executes push/pop

---
 rtl/stack_controller_if.sv | 37 +++
 rtl/stack_controller.sv | 127 ++++++++++++
 2 files changed

// File: rtl/stack_controller_if.sv
// rtl/stack_controller_if.sv - request and data-memory bus interfaces for stack_controller
interface stack_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_push;
    logic [31:0] req_data;
    logic [5:0]  req_rd;

    modport master (
        output req_valid, req_push, req_data, req_rd,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_push, req_data, req_rd,
        output req_ready
    );
endinterface

interface stack_mem_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - full-descending stack push/pop engine with shadow SP
module stack_controller #(
    parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800,
    parameter int          WORD_BYTES  = 4,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    stack_req_if.slave  req,
    stack_mem_if.master mem,
    output logic [31:0] sp,
    output logic [31:0] sp_new,
    output logic        stack_op,
    output logic        reg_write,
    output logic [5:0]  reg_rd,
    output logic [31:0] reg_data,
    output logic        overflow,
    output logic        underflow,
    output logic        timeout
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MEM, COMMIT, ERR} state_t;

    state_t            state;
    logic [31:0]       next_sp;
    logic              is_push;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       push_next;
    logic [31:0]       pop_next;

    assign push_next = sp - 32'(WORD_BYTES);
    assign pop_next  = sp + 32'(WORD_BYTES);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            sp            <= STACK_BASE;
            next_sp       <= '0;
            is_push       <= 1'b0;
            cnt           <= '0;
            req.req_ready <= 1'b1;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_we    <= 1'b0;
            mem.mem_re    <= 1'b0;
            sp_new        <= '0;
            stack_op      <= 1'b0;
            reg_write     <= 1'b0;
            reg_rd        <= '0;
            reg_data      <= '0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            stack_op  <= 1'b0;
            reg_write <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        req.req_ready <= 1'b0;
                        cnt           <= '0;
                        is_push       <= req.req_push;
                        // Bounds are resolved here so a rejected request never touches memory.
                        if (req.req_push) begin
                            if (push_next < STACK_LIMIT) begin
                                overflow <= 1'b1;
                                state    <= ERR;
                            end else begin
                                mem.mem_addr  <= push_next;
                                mem.mem_wdata <= req.req_data;
                                mem.mem_we    <= 1'b1;
                                next_sp       <= push_next;
                                state         <= MEM;
                            end
                        end else begin
                            if (sp >= STACK_BASE) begin
                                underflow <= 1'b1;
                                state     <= ERR;
                            end else begin
                                mem.mem_addr <= sp;
                                mem.mem_re   <= 1'b1;
                                next_sp      <= pop_next;
                                reg_rd       <= req.req_rd;
                                state        <= MEM;
                            end
                        end
                    end
                end
                MEM: begin
                    if (mem.mem_ack) begin
                        mem.mem_we <= 1'b0;
                        mem.mem_re <= 1'b0;
                        stack_op   <= 1'b1;
                        sp_new     <= next_sp;
                        sp         <= next_sp;
                        if (!is_push) begin
                            reg_data  <= mem.mem_rdata;
                            reg_write <= (reg_rd != 6'd0);
                        end
                        state <= COMMIT;
                    end else if (cnt == CNT_LAST) begin
                        mem.mem_we <= 1'b0;
                        mem.mem_re <= 1'b0;
                        timeout    <= 1'b1;
                        state      <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMMIT, ERR: begin
                    req.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    req.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule
